// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if: start/done handshake and operand/result bus of the serial subtractor
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    modport master (output start, a, b, input busy, done, diff, borrow);
    modport slave  (input start, a, b, output busy, done, diff, borrow);
endinterface

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial unsigned a - b, LSB first, one bit per clock, start/done handshake
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    serial_subtractor_if.slave sif
);
    localparam int CNT_W = $clog2(WIDTH) + 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d, sb_q, sb_d, rd_q, rd_d, diff_q, diff_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             bf_q, bf_d, borrow_q, borrow_d, busy_q, done_q;
    logic             d, bout, last;
    always_comb begin
        d        = sa_q[0] ^ sb_q[0] ^ bf_q;
        bout     = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & bf_q);
        last     = (cnt_q == CNT_W'(WIDTH - 1));
        state_d  = state_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        rd_d     = rd_q;
        bf_d     = bf_q;
        cnt_d    = cnt_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        if (state_q == IDLE && sif.start) begin
            state_d = RUN;
            sa_d    = sif.a;
            sb_d    = sif.b;
            rd_d    = '0;
            bf_d    = 1'b0;
            cnt_d   = '0;
        end else if (state_q == RUN) begin
            sa_d  = sa_q >> 1;
            sb_d  = sb_q >> 1;
            rd_d  = {d, rd_q[WIDTH-1:1]};
            bf_d  = bout;
            cnt_d = cnt_q + CNT_W'(1);
            // Result registers only move on the completion edge so the previous result stays visible during RUN
            state_d  = last ? DONE : RUN;
            diff_d   = last ? {d, rd_q[WIDTH-1:1]} : diff_q;
            borrow_d = last ? bout : borrow_q;
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sa_q     <= '0;
            sb_q     <= '0;
            rd_q     <= '0;
            bf_q     <= 1'b0;
            cnt_q    <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            rd_q     <= rd_d;
            bf_q     <= bf_d;
            cnt_q    <= cnt_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            busy_q   <= (state_d != IDLE);
            done_q   <= (state_d == DONE);
        end
    end
    assign sif.busy   = busy_q;
    assign sif.done   = done_q;
    assign sif.diff   = diff_q;
    assign sif.borrow = borrow_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed handshake tests plus randomised scoreboard check at WIDTH=8 and WIDTH=16
module tb_serial_subtractor;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;
    serial_subtractor_if #(.WIDTH(8))  i8 ();
    serial_subtractor_if #(.WIDTH(16)) i16 ();
    serial_subtractor #(.WIDTH(8))  u8  (.clk(clk), .rst_n(rst_n), .sif(i8));
    serial_subtractor #(.WIDTH(16)) u16 (.clk(clk), .rst_n(rst_n), .sif(i16));
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          acc[2];
    int          dn[2];
    logic        pd[2];
    logic [32:0] eq[2][$];
    int          tq[2][$];
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask
    // Scoreboard: an operation is accepted at the edge following a negedge that sees busy=0 and start=1
    task automatic mon(input int k, input int w, input logic busy, input logic start, input logic done,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] diff, input logic borrow);
        logic [32:0] m, e;
        int t;
        if (!rst_n) begin
            acc[k] -= eq[k].size();
            eq[k].delete();
            tq[k].delete();
            pd[k] = 1'b0;
            return;
        end
        if (done) begin
            dn[k]++;
            check("done_width", 64'(pd[k]), 0);
            check("done_expected", 64'(eq[k].size() != 0), 1);
            if (eq[k].size() != 0) begin
                e = eq[k].pop_front();
                t = tq[k].pop_front();
                check("result", 64'((33'(borrow) << w) | 33'(diff)), 64'(e));
                check("latency", 64'(cyc - t), 64'(w + 1));
            end
        end
        pd[k] = done;
        if (!busy && start) begin
            m = (33'd1 << (w + 1)) - 33'd1;
            eq[k].push_back(({1'b0, a} - {1'b0, b}) & m);
            tq[k].push_back(cyc);
            acc[k]++;
        end
    endtask
    always @(negedge clk) begin
        cyc++;
        mon(0, 8, i8.busy, i8.start, i8.done, 32'(i8.a), 32'(i8.b), 32'(i8.diff), i8.borrow);
        mon(1, 16, i16.busy, i16.start, i16.done, 32'(i16.a), 32'(i16.b), 32'(i16.diff), i16.borrow);
    end
    task automatic step();
        @(posedge clk);
        #2;
    endtask
    task automatic go8(input logic [7:0] a, input logic [7:0] b);
        i8.a = a;
        i8.b = b;
        i8.start = 1'b1;
        step();
        i8.start = 1'b0;
    endtask
    task automatic wait_done8();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i8.done) break;
        end
        check("wait_done", 64'(i8.done), 1);
        step();
    endtask
    task automatic rand_drive(input int k);
        logic [31:0] x, y;
        logic s;
        for (int n = 0; n < 30000 && acc[k] < 1000; n++) begin
            step();
            s = ($urandom_range(0, 3) != 0);
            x = $urandom;
            y = ($urandom_range(0, 7) == 0) ? x : $urandom;
            if ($urandom_range(0, 15) == 0) begin
                x = '0;
                y = '1;
            end
            if (k == 0) begin
                i8.start = s;
                i8.a = x[7:0];
                i8.b = y[7:0];
            end else begin
                i16.start = s;
                i16.a = x[15:0];
                i16.b = y[15:0];
            end
        end
        if (k == 0) i8.start = 1'b0;
        else i16.start = 1'b0;
    endtask
    initial begin
        int nd;
        i8.start = 1'b0;
        i8.a = '0;
        i8.b = '0;
        i16.start = 1'b0;
        i16.a = '0;
        i16.b = '0;
        #3 rst_n = 1'b0;
        #1 check("reset8", 64'({i8.busy, i8.done, i8.diff, i8.borrow}), 0);
        check("reset16", 64'({i16.busy, i16.done, i16.diff, i16.borrow}), 0);
        repeat (2) step();
        rst_n = 1'b1;
        step();
        go8(8'h5A, 8'h23);
        @(negedge clk);
        check("busy_rise", 64'(i8.busy), 1);
        wait_done8();
        check("diff_5a_23", 64'({i8.borrow, i8.diff}), 64'h037);
        check("busy_idle", 64'(i8.busy), 0);
        go8(8'h00, 8'h01);
        wait_done8();
        go8(8'hC3, 8'hC3);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i8.done) break;
            check("hold_ff", 64'({i8.borrow, i8.diff}), 64'h1FF);
        end
        step();
        check("diff_c3_c3", 64'({i8.borrow, i8.diff}), 0);
        i8.start = 1'b1;
        i8.a = 8'h10;
        i8.b = 8'h01;
        nd = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i8.done) begin
                nd++;
                check("diff_10_01", 64'(i8.diff), 64'h0F);
            end
            step();
            i8.a = i8.busy ? 8'($urandom) : 8'h10;
            i8.b = i8.busy ? 8'($urandom) : 8'h01;
        end
        i8.start = 1'b0;
        check("back_to_back_count", 64'(nd), 4);
        repeat (3) step();
        go8(8'h80, 8'h01);
        wait_done8();
        check("diff_80_01", 64'(i8.diff), 64'h7F);
        go8(8'hFF, 8'h0F);
        repeat (4) @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check("abort_outputs", 64'({i8.busy, i8.done, i8.diff, i8.borrow}), 0);
        repeat (2) step();
        rst_n = 1'b1;
        step();
        check("abort_no_done", 64'(dn[0]), 64'(acc[0]));
        go8(8'h34, 8'h12);
        wait_done8();
        check("diff_34_12", 64'({i8.borrow, i8.diff}), 64'h022);
        fork
            rand_drive(0);
            rand_drive(1);
        join
        repeat (40) step();
        check("ops8", 64'(acc[0] >= 1000), 1);
        check("ops16", 64'(acc[1] >= 1000), 1);
        check("done_count8", 64'(dn[0]), 64'(acc[0]));
        check("done_count16", 64'(dn[1]), 64'(acc[1]));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
